// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: FSM states and requester side.
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

endpackage

// File: rtl/memory_port_arbiter_fairness_counter.sv
// Saturating count of data grants made while fetch waits; forces a fetch grant at the limit.
module arb_fairness_counter #(
  parameter int BURST_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_idle,
  input  logic i_fetch_req,
  input  logic i_data_grant,
  input  logic i_fetch_grant,
  output logic o_force_fetch
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CountMax = CW'(BURST_MAX);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_fetch_grant || (i_idle && !i_fetch_req)) begin
      r_count <= '0;
    end else if (i_data_grant && i_fetch_req && (r_count != CountMax)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_force_fetch = i_fetch_req && (r_count == CountMax);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-ported memory between fetch and data; one transaction in flight, data first.
// MEMORY_PORT_ARBITER_FAIRNESS_EN bounds fetch starvation to DATA_BURST_MAX consecutive data grants.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_BITS   = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_BURST_MAX = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_read,
  input  logic [ADDRESS_BITS-1:0]   i_address,
  output logic                      i_ready,
  output logic                      i_valid,
  output logic [DATA_WIDTH-1:0]     i_data_out,
  output logic [ADDRESS_BITS-1:0]   i_address_out,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [ADDRESS_BITS-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]     d_data_in,
  input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
  output logic                      d_ready,
  output logic                      d_valid,
  output logic [DATA_WIDTH-1:0]     d_data_out,
  output logic [ADDRESS_BITS-1:0]   d_address_out,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDRESS_BITS-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  input  logic                      mem_ready,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_data_in
);

  if (DATA_BURST_MAX < 1) begin : g_burst_check
    $error("DATA_BURST_MAX must be at least 1");
  end

  state_t                    r_state;
  state_t                    w_next_state;
  side_t                     r_side;
  logic [ADDRESS_BITS-1:0]   r_addr;
  logic [ADDRESS_BITS-1:0]   r_rsp_addr;
  logic [DATA_WIDTH-1:0]     r_rsp_data;
  logic                      w_idle;
  logic                      w_force_fetch;
  logic                      w_pick_d;
  logic                      w_pick_i;
  logic                      w_accept;

  // Commands only leave the block from IDLE, and never while reset is held.
  assign w_idle = reset && (r_state == IDLE);

`ifdef MEMORY_PORT_ARBITER_FAIRNESS_EN
  arb_fairness_counter #(
    .BURST_MAX     (DATA_BURST_MAX)
  ) u_fairness (
    .clock         (clock),
    .reset         (reset),
    .i_idle        (w_idle),
    .i_fetch_req   (i_read),
    .i_data_grant  (d_ready),
    .i_fetch_grant (i_ready),
    .o_force_fetch (w_force_fetch)
  );
`else
  assign w_force_fetch = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pick_d     = (d_read || d_write) && !w_force_fetch;
    w_pick_i     = i_read && !w_pick_d;
    mem_read     = w_idle && ((w_pick_d && d_read) || w_pick_i);
    mem_write    = w_idle && w_pick_d && d_write;
    mem_address  = '0;
    mem_data_out = '0;
    mem_byte_en  = '0;
    if (w_idle && w_pick_d) begin
      mem_address = d_address;
    end else if (w_idle && w_pick_i) begin
      mem_address = i_address;
    end
    if (mem_write) begin
      mem_data_out = d_data_in;
      mem_byte_en  = d_byte_en;
    end
    w_accept = (mem_read || mem_write) && mem_ready;
    i_ready  = w_accept && w_pick_i;
    d_ready  = w_accept && w_pick_d;

    // Stores are posted: an accepted write leaves the FSM in IDLE.
    case (r_state)
      IDLE:           if (w_accept && mem_read) w_next_state = w_pick_d ? D_WAIT : I_WAIT;
      I_WAIT, D_WAIT: if (mem_valid) w_next_state = RESP;
      RESP:           w_next_state = IDLE;
      default:        w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_side     <= SIDE_I;
      r_addr     <= '0;
      r_rsp_addr <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_side <= w_pick_d ? SIDE_D : SIDE_I;
        r_addr <= mem_address;
      end
      if (((r_state == I_WAIT) || (r_state == D_WAIT)) && mem_valid) begin
        r_rsp_data <= mem_data_in;
        r_rsp_addr <= r_addr;
      end
    end
  end

  assign i_valid       = (r_state == RESP) && (r_side == SIDE_I);
  assign d_valid       = (r_state == RESP) && (r_side == SIDE_D);
  assign i_data_out    = r_rsp_data;
  assign d_data_out    = r_rsp_data;
  assign i_address_out = r_rsp_addr;
  assign d_address_out = r_rsp_addr;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: vector table, directed corner cases, random traffic.
module tb_memory_port_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int BURST = 4;
  localparam logic [7:0] G_D = 8'h44;
  localparam logic [7:0] G_I = 8'h49;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic          i_ready, i_valid;
  logic [DW-1:0] i_data_out;
  logic [AW-1:0] i_address_out;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_data_in = '0;
  logic [BW-1:0] d_byte_en = '0;
  logic          d_ready, d_valid;
  logic [DW-1:0] d_data_out;
  logic [AW-1:0] d_address_out;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out;
  logic [BW-1:0] mem_byte_en;
  logic          mem_ready = 1'b0, mem_valid = 1'b0;
  logic [DW-1:0] mem_data_in = '0;

  memory_port_arbiter #(
    .ADDRESS_BITS(AW), .DATA_WIDTH(DW), .DATA_BURST_MAX(BURST)
  ) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid),
    .i_data_out(i_data_out), .i_address_out(i_address_out),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_data_in(d_data_in),
    .d_byte_en(d_byte_en), .d_ready(d_ready), .d_valid(d_valid),
    .d_data_out(d_data_out), .d_address_out(d_address_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_byte_en(mem_byte_en),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_data_in(mem_data_in)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic outs_or();
    return |{i_ready, i_valid, i_data_out, i_address_out, d_ready, d_valid, d_data_out,
             d_address_out, mem_read, mem_write, mem_address, mem_data_out, mem_byte_en};
  endfunction

  // Reference view of memory (updated from the bench's own knowledge of granted stores)
  // and the physical memory seen through the DUT's memory port.
  logic [DW-1:0] ref_mem  [int];
  logic [DW-1:0] phys_mem [int];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  function automatic logic [DW-1:0] phys_rd(input logic [AW-1:0] a);
    return phys_mem.exists(int'(a)) ? phys_mem[int'(a)] : '0;
  endfunction

  // Automatic memory: random accept stalls, random 0..3 cycle read latency.
  bit            auto_mem = 1'b0;
  bit            pend = 1'b0;
  int            lat = 0;
  logic [AW-1:0] paddr = '0;

  initial forever begin
    @(negedge clock);
    if (auto_mem) begin
      mem_valid = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          mem_valid   = 1'b1;
          mem_data_in = phys_rd(paddr);
          pend        = 1'b0;
        end else begin
          lat--;
        end
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (mem_ready && mem_read) begin
        pend  = 1'b1;
        paddr = mem_address;
        lat   = $urandom_range(0, 3);
      end
      if (mem_ready && mem_write)
        phys_mem[int'(mem_address)] = merge(phys_rd(mem_address), mem_data_out, mem_byte_en);
    end
  end

  int dv_cnt = 0, iv_cnt = 0;
  always @(negedge clock) begin
    if (d_valid === 1'b1) dv_cnt++;
    if (i_valid === 1'b1) iv_cnt++;
  end

  bit         log_en = 1'b0;
  logic [7:0] glog [$];
  always @(negedge clock) begin
    if (log_en) begin
      #2;
      if (d_ready === 1'b1) glog.push_back(G_D);
      if (i_ready === 1'b1) glog.push_back(G_I);
    end
  end

  logic [7:0] order [$];
  int exp_dv = 0, exp_iv = 0;

  task automatic run_data(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be);
    int n; bit got; logic [DW-1:0] expd;
    expd = '0;
    @(negedge clock);
    d_read = !wr; d_write = wr; d_address = a; d_data_in = wd; d_byte_en = be;
    got = 1'b0; n = 0;
    while (!got && n < 200) begin
      #2;
      if (d_ready === 1'b1) got = 1'b1;
      else begin @(negedge clock); n++; end
    end
    chk("d_grant", got, 1);
    order.push_back(G_D);
    if (wr) ref_mem[int'(a)] = merge(ref_rd(a), wd, be);
    else expd = ref_rd(a);
    @(negedge clock);
    d_read = 1'b0; d_write = 1'b0;
    if (!wr && got) begin
      exp_dv++;
      got = 1'b0; n = 0;
      while (!got && n < 200) begin
        #2;
        if (d_valid === 1'b1) got = 1'b1;
        else begin @(negedge clock); n++; end
      end
      chk("d_rsp_seen", got, 1);
      chk("d_rsp_data", d_data_out, expd);
      chk("d_rsp_addr", d_address_out, a);
    end
  endtask

  task automatic run_fetch(input logic [AW-1:0] a);
    int n; bit got; logic [DW-1:0] expd;
    @(negedge clock);
    i_read = 1'b1; i_address = a;
    got = 1'b0; n = 0;
    while (!got && n < 200) begin
      #2;
      if (i_ready === 1'b1) got = 1'b1;
      else begin @(negedge clock); n++; end
    end
    chk("i_grant", got, 1);
    order.push_back(G_I);
    expd = ref_rd(a);
    @(negedge clock);
    i_read = 1'b0;
    if (got) begin
      exp_iv++;
      got = 1'b0; n = 0;
      while (!got && n < 200) begin
        #2;
        if (i_valid === 1'b1) got = 1'b1;
        else begin @(negedge clock); n++; end
      end
      chk("i_rsp_seen", got, 1);
      chk("i_rsp_data", i_data_out, expd);
      chk("i_rsp_addr", i_address_out, a);
    end
  endtask

  typedef struct {
    logic ir, dr, dw, mr;
    logic [AW-1:0] ia, da;
    logic emr, emw, eir, edr, ca;
    logic [AW-1:0] ema;
  } vec_t;

  vec_t vt [9];
  int   pat, dv0, iv0, cnt;
  logic [AW-1:0] a_d, a_i;
  logic [DW-1:0] wdat;
  logic [BW-1:0] wbe;
  bit   fair_en;
  logic [7:0] eg;

  initial begin
    vt[0] = '{1'b0,1'b0,1'b0,1'b1, 20'h0,     20'h0,     1'b0,1'b0,1'b0,1'b0, 1'b0, 20'h0};
    vt[1] = '{1'b1,1'b0,1'b0,1'b1, 20'h11110, 20'h0,     1'b1,1'b0,1'b1,1'b0, 1'b1, 20'h11110};
    vt[2] = '{1'b1,1'b0,1'b0,1'b0, 20'h22220, 20'h0,     1'b1,1'b0,1'b0,1'b0, 1'b1, 20'h22220};
    vt[3] = '{1'b0,1'b1,1'b0,1'b1, 20'h0,     20'h33330, 1'b1,1'b0,1'b0,1'b1, 1'b1, 20'h33330};
    vt[4] = '{1'b0,1'b0,1'b1,1'b1, 20'h0,     20'h44440, 1'b0,1'b1,1'b0,1'b1, 1'b1, 20'h44440};
    vt[5] = '{1'b1,1'b1,1'b0,1'b1, 20'h55550, 20'h55554, 1'b1,1'b0,1'b0,1'b1, 1'b1, 20'h55554};
    vt[6] = '{1'b1,1'b0,1'b1,1'b1, 20'h66660, 20'h66664, 1'b0,1'b1,1'b0,1'b1, 1'b1, 20'h66664};
    vt[7] = '{1'b1,1'b1,1'b0,1'b0, 20'h77770, 20'h77774, 1'b1,1'b0,1'b0,1'b0, 1'b1, 20'h77774};
    vt[8] = '{1'b1,1'b0,1'b1,1'b0, 20'h88880, 20'h88884, 1'b0,1'b1,1'b0,1'b0, 1'b1, 20'h88884};

    for (int k = 0; k < 16; k++) begin
      wdat = $urandom;
      ref_mem[k*4]  = wdat;
      phys_mem[k*4] = wdat;
    end

    // Outputs stay quiet while reset is held, even with requests pending.
    i_read = 1'b1; d_write = 1'b1; d_address = 20'h123; i_address = 20'h456; mem_ready = 1'b1;
    #2 chk("reset_outs", outs_or(), 0);
    i_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < 9; v++) begin
      @(negedge clock);
      i_read = vt[v].ir; d_read = vt[v].dr; d_write = vt[v].dw; mem_ready = vt[v].mr;
      i_address = vt[v].ia; d_address = vt[v].da;
      #1;
      chk($sformatf("vec%0d_mem_read", v), mem_read, vt[v].emr);
      chk($sformatf("vec%0d_mem_write", v), mem_write, vt[v].emw);
      chk($sformatf("vec%0d_i_ready", v), i_ready, vt[v].eir);
      chk($sformatf("vec%0d_d_ready", v), d_ready, vt[v].edr);
      if (vt[v].ca) chk($sformatf("vec%0d_mem_address", v), mem_address, vt[v].ema);
      #1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
    end

    // Single fetch, mem_valid three cycles after accept.
    @(negedge clock);
    i_read = 1'b1; i_address = 20'h00104; mem_ready = 1'b1;
    #1 chk("fetch_ready", i_ready, 1); chk("fetch_mem_read", mem_read, 1);
    chk("fetch_mem_addr", mem_address, 20'h00104);
    @(negedge clock); i_read = 1'b0; mem_ready = 1'b0;
    #1 chk("fetch_wait_no_cmd", mem_read, 0);
    @(negedge clock);
    @(negedge clock); mem_valid = 1'b1; mem_data_in = 32'hDEADBEEF;
    #1 chk("fetch_valid_early", i_valid, 0);
    @(negedge clock); mem_valid = 1'b0; mem_data_in = '0;
    #1 chk("fetch_valid", i_valid, 1); chk("fetch_data", i_data_out, 32'hDEADBEEF);
    chk("fetch_addr_out", i_address_out, 20'h00104); chk("fetch_no_d_valid", d_valid, 0);
    @(negedge clock);
    #1 chk("fetch_valid_one_cycle", i_valid, 0);

    // Contention: data first, fetch accepted two cycles after the load's mem_valid.
    @(negedge clock);
    i_read = 1'b1; i_address = 20'h00200; d_read = 1'b1; d_address = 20'h80010; mem_ready = 1'b1;
    #1 chk("cont_d_ready", d_ready, 1); chk("cont_i_ready", i_ready, 0);
    chk("cont_mem_addr", mem_address, 20'h80010);
    @(negedge clock); d_read = 1'b0;
    #1 chk("cont_wait_i_ready", i_ready, 0);
    @(negedge clock); mem_valid = 1'b1; mem_data_in = 32'h0BADF00D;
    @(negedge clock); mem_valid = 1'b0;
    #1 chk("cont_d_valid", d_valid, 1); chk("cont_d_data", d_data_out, 32'h0BADF00D);
    chk("cont_d_addr_out", d_address_out, 20'h80010); chk("cont_resp_no_cmd", i_ready, 0);
    @(negedge clock);
    #1 chk("cont_i_ready_late", i_ready, 1); chk("cont_i_mem_addr", mem_address, 20'h00200);
    @(negedge clock); i_read = 1'b0; mem_ready = 1'b0;
    @(negedge clock); mem_valid = 1'b1; mem_data_in = 32'h12345678;
    @(negedge clock); mem_valid = 1'b0;
    #1 chk("cont_i_valid", i_valid, 1); chk("cont_i_data", i_data_out, 32'h12345678);
    chk("cont_i_addr_out", i_address_out, 20'h00200);

    // Posted store followed immediately by a fetch.
    @(negedge clock);
    d_write = 1'b1; d_address = 20'h00300; d_data_in = 32'hA5A5A5A5; d_byte_en = 4'b0011;
    mem_ready = 1'b1;
    #1 chk("st_d_ready", d_ready, 1); chk("st_mem_write", mem_write, 1);
    chk("st_mem_read", mem_read, 0); chk("st_byte_en", mem_byte_en, 4'b0011);
    chk("st_data", mem_data_out, 32'hA5A5A5A5); chk("st_addr", mem_address, 20'h00300);
    @(negedge clock); d_write = 1'b0; d_byte_en = '0; i_read = 1'b1; i_address = 20'h00104;
    #1 chk("st_no_d_valid", d_valid, 0); chk("st_next_fetch", i_ready, 1);
    @(negedge clock); i_read = 1'b0; mem_ready = 1'b0;
    #1 chk("st_no_d_valid2", d_valid, 0);
    @(negedge clock); mem_valid = 1'b1; mem_data_in = 32'h55;
    @(negedge clock); mem_valid = 1'b0;
    #1 chk("st_fetch_valid", i_valid, 1); chk("st_no_d_valid3", d_valid, 0);
    @(negedge clock);

    // Backpressure for five cycles, then reset in the middle of the read.
    @(negedge clock); d_read = 1'b1; d_address = 20'h40404; mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      #1 chk($sformatf("bp%0d_d_ready", k), d_ready, 0);
      chk($sformatf("bp%0d_mem_addr", k), mem_address, 20'h40404);
      chk($sformatf("bp%0d_mem_read", k), mem_read, 1);
    end
    @(negedge clock); mem_ready = 1'b1;
    #1 chk("bp_release_d_ready", d_ready, 1);
    @(negedge clock); d_read = 1'b0; mem_ready = 1'b0;
    @(negedge clock); reset = 1'b0; i_read = 1'b1; d_read = 1'b1; mem_ready = 1'b1;
    #1 chk("reset_mid_outs", outs_or(), 0);
    @(negedge clock); i_read = 1'b0; d_read = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    @(negedge clock); mem_valid = 1'b1; mem_data_in = 32'hBAD;
    #1 chk("stale_valid_a", d_valid, 0);
    @(negedge clock); mem_valid = 1'b0;
    #1 chk("stale_valid_b", d_valid, 0); chk("stale_valid_i", i_valid, 0);
    @(negedge clock); d_read = 1'b1; d_address = 20'h00040;
    #1 chk("post_reset_idle", mem_read, 1);
    #1 d_read = 1'b0;

    // Random traffic against the reference memory.
    dv0 = dv_cnt; iv0 = iv_cnt;
    pend = 1'b0; auto_mem = 1'b1;
    for (int it = 0; it < 40; it++) begin
      pat  = $urandom_range(0, 4);
      a_d  = AW'($urandom_range(0, 15) * 4);
      a_i  = AW'($urandom_range(0, 15) * 4);
      wdat = $urandom;
      wbe  = BW'($urandom_range(1, 15));
      order.delete();
      fork
        begin if (pat != 0) run_data(pat == 2 || pat == 4, a_d, wdat, wbe); end
        begin if (pat == 0 || pat >= 3) run_fetch(a_i); end
      join
      if (pat >= 3) chk($sformatf("rnd%0d_data_first", it), order[0], G_D);
      repeat (2) @(negedge clock);
    end
    repeat (8) @(negedge clock);
    chk("rnd_d_valid_count", dv_cnt - dv0, exp_dv);
    chk("rnd_i_valid_count", iv_cnt - iv0, exp_iv);

    // Sustained data traffic with fetch waiting.
`ifdef MEMORY_PORT_ARBITER_FAIRNESS_EN
    fair_en = 1'b1;
`else
    fair_en = 1'b0;
`endif
    glog.delete();
    @(negedge clock);
    d_read = 1'b1; d_address = 20'h8; i_read = 1'b1; i_address = 20'hC; log_en = 1'b1;
    for (int n = 0; n < 2000 && glog.size() < 10; n++) @(negedge clock);
    log_en = 1'b0; d_read = 1'b0; i_read = 1'b0;
    chk("fair_grants_seen", glog.size() >= 10, 1);
    cnt = 0;
    for (int k = 0; k < 10 && k < glog.size(); k++) begin
      if (fair_en && cnt == BURST) begin eg = G_I; cnt = 0; end
      else begin eg = G_D; cnt++; end
      chk($sformatf("fair_grant%0d", k), glog[k], eg);
    end
    repeat (12) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one single-ported, variable-latency memory between the core's instruction-fetch side and data-access side. Sits between the fetch/memory stages and the unified memory. Returns responses tagged with their address so the core's i-mem/d-mem hazard checks (valid plus address match) work unchanged. Allows one outstanding transaction at a time. Data has priority; an optional fairness counter bounds fetch starvation.

## Interface
- ADDRESS_BITS, 20, address width for both requesters and the memory
- DATA_WIDTH, 32, data word width; byte enables are DATA_WIDTH/8
- DATA_BURST_MAX, 4, consecutive data grants allowed while fetch is waiting (used only with the fairness guard)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_read  in  1  fetch read request; held until accepted
- i_address  in  ADDRESS_BITS  fetch address
- i_ready  out  1  one-cycle pulse when the fetch request is accepted
- i_valid  out  1  one-cycle pulse when fetch read data is returned
- i_data_out  out  DATA_WIDTH  fetch read data
- i_address_out  out  ADDRESS_BITS  address of the returned fetch data
- d_read, d_write  in  1 each  data request; held until accepted; never both high
- d_address  in  ADDRESS_BITS  data address
- d_data_in  in  DATA_WIDTH  store data
- d_byte_en  in  DATA_WIDTH/8  store byte enables
- d_ready, d_valid  out  1 each  accept pulse, load-return pulse
- d_data_out  out  DATA_WIDTH  load data
- d_address_out  out  ADDRESS_BITS  address of the returned load
- mem_read, mem_write  out  1 each  memory command
- mem_address  out  ADDRESS_BITS  memory command address
- mem_data_out  out  DATA_WIDTH  memory store data
- mem_byte_en  out  DATA_WIDTH/8  memory store byte enables
- mem_ready  in  1  memory accepts the command this cycle
- mem_valid  in  1  memory read data valid
- mem_data_in  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, I_WAIT, D_WAIT, RESP.
- **IDLE**
  - Select a winner: data if d_read|d_write, otherwise fetch if i_read.
  - Drive mem_* combinationally from the winner.
  - When mem_ready=1, pulse the winner's *_ready and latch its address and side.
  - Next state: read goes to I_WAIT or D_WAIT; write stays in IDLE (posted, no response).
- **I_WAIT / D_WAIT**
  - mem_read and mem_write are 0.
  - On mem_valid, register mem_data_in and the latched address into the response registers, then go to RESP.
- **RESP**
  - Assert i_valid or d_valid for exactly one cycle with the registered data and address.
  - Return to IDLE. No new command is issued in RESP.
- Outside I_WAIT/D_WAIT, mem_valid is ignored.
- With no request, or mem_ready=0, mem_* addresses and data are don't-care, but mem_read and mem_write follow the requests.
- Reset (any time, including mid-transaction): state goes to IDLE and the outstanding read is dropped. A stale mem_valid after reset is ignored.
- Reset values: every output 0; response and latched registers 0; fairness counter 0.

## Timing
- Accept: combinational. *_ready rises in the same cycle that mem_read/mem_write and mem_ready are both high.
- Read latency: N = mem_valid cycle; *_valid is asserted in cycle N+1.
- Back-to-back: the next command is possible in cycle N+2.
- Writes: one per cycle while mem_ready=1.
- A requester must hold its request and operands stable until *_ready.
- Simultaneous fetch and data requests in IDLE: data wins, except when the fairness guard overrides (see Configuration).

## Configuration
- Macro: MEMORY_PORT_ARBITER_FAIRNESS_EN.
- **Defined:**
  - A counter of consecutive data grants made while i_read=1.
  - Saturates at DATA_BURST_MAX. When it equals DATA_BURST_MAX and i_read=1, the next accepted grant goes to fetch.
  - The counter clears on any fetch grant, and whenever i_read=0 in IDLE.
- **Undefined:** strict data priority; the counter logic is absent.

## Structure
- Package memory_port_arbiter_pkg holds:
  - the state enum (IDLE, I_WAIT, D_WAIT, RESP)
  - the side encoding (SIDE_I, SIDE_D)
- Sub-module arb_fairness_counter holds the saturating grant counter and produces the force-fetch output. It is instantiated only under the macro.

## Test plan
- **Single fetch:** i_read=1, i_address=0x00104, mem_ready=1, mem_valid 3 cycles later with data 0xDEADBEEF -> i_ready pulse in the issue cycle; i_valid one cycle after mem_valid with i_data_out=0xDEADBEEF and i_address_out=0x00104.
- **Contention:** i_read and d_read both high at addresses 0x00200 and 0x80010 -> data accepted first; fetch accepted 2 cycles after the d_valid-triggering mem_valid.
- **Posted store:** d_write, d_byte_en=4'b0011, mem_ready=1 -> d_ready the same cycle, mem_write and mem_byte_en=0011, no d_valid; a following i_read is accepted the next cycle.
- **Backpressure:** mem_ready=0 for 5 cycles with d_read held -> no d_ready until mem_ready=1; mem_address stable at the d_address value throughout.
- **Reset mid-read:** reset low in D_WAIT, then mem_valid pulses after release -> d_valid stays 0; all outputs 0 during reset.
- **Fairness (macro defined, DATA_BURST_MAX=4):** continuous d_read with i_read held -> exactly 4 data grants, then 1 fetch grant, repeating. Macro undefined -> fetch never granted.
